// File: rtl/head_table_pkg.sv
// hash_table package: default widths, head-RAM entry layout and FSM state
// type shared by the head_table block.
package hash_table;

    localparam int BUCKET_WIDTH_DEF   = 8;
    localparam int HEAD_PTR_WIDTH_DEF = 10;

    // One head-table entry: pointer into the data table plus its valid flag.
    typedef struct packed {
        logic [HEAD_PTR_WIDTH_DEF-1:0] head_ptr;
        logic                          head_ptr_val;
    } head_ram_data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/true_dual_port_ram_single_clock.sv
// Two-port synchronous RAM on one clock.
// Ports: clk_i; port A en_a/we_a/addr_a/data_a -> q_a (read-first, q_a holds
// when en_a is low); port B we_b/addr_b/data_b is write-only. On a same-address
// double write, port B wins. No reset: contents are undefined until written.
module true_dual_port_ram_single_clock #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_a) mem[addr_a] <= data_a;
        if (en_a) q_a <= mem[addr_a];
        if (we_b) mem[addr_b] <= data_b;
    end

endmodule

// File: rtl/head_table.sv
// head_table: bucket -> {head_ptr, head_ptr_val} lookup table with a full
// clear sweep and a write port driven by the data table.
// Ports:
//   clk_i, rst_n_i                     clock, async active-low reset
//   lk_valid_i/lk_ready_o, lk_bucket_i, lk_tag_i     lookup request
//   res_valid_o/res_ready_i, res_bucket_o, res_tag_o,
//   res_head_ptr_o, res_head_ptr_val_o               lookup result
//   upd_wr_en_i, upd_bucket_i, upd_head_ptr_i, upd_head_ptr_val_i  head write
//   clear_ram_run_i, clear_ram_done_o                clear sweep control
// Build option: define HEAD_TABLE_CLEAR_ON_RESET_EN to start a clear sweep
// automatically after reset release (lookups blocked until it completes).
module head_table
    import hash_table::*;
#(
    parameter int BUCKET_WIDTH   = BUCKET_WIDTH_DEF,
    parameter int HEAD_PTR_WIDTH = HEAD_PTR_WIDTH_DEF,
    parameter int TAG_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      lk_valid_i,
    output logic                      lk_ready_o,
    input  logic [BUCKET_WIDTH-1:0]   lk_bucket_i,
    input  logic [TAG_WIDTH-1:0]      lk_tag_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [BUCKET_WIDTH-1:0]   res_bucket_o,
    output logic [TAG_WIDTH-1:0]      res_tag_o,
    output logic [HEAD_PTR_WIDTH-1:0] res_head_ptr_o,
    output logic                      res_head_ptr_val_o,
    input  logic                      upd_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0]   upd_bucket_i,
    input  logic [HEAD_PTR_WIDTH-1:0] upd_head_ptr_i,
    input  logic                      upd_head_ptr_val_i,
    input  logic                      clear_ram_run_i,
    output logic                      clear_ram_done_o
);

    localparam int DW = HEAD_PTR_WIDTH + 1;
    localparam logic [BUCKET_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    logic [BUCKET_WIDTH-1:0] clr_addr;
    logic [BUCKET_WIDTH-1:0] clr_nxt;
    logic                    start_clr;
    logic                    init_pend;

    logic                    lk_fire;
    logic                    upd_we;
    logic                    we_b;
    logic [BUCKET_WIDTH-1:0] addr_b;
    logic [DW-1:0]           data_b;
    logic [DW-1:0]           upd_data;
    logic [DW-1:0]           q_a;

    logic                    fresh;     // first result cycle: data comes from RAM/bypass
    logic                    byp_hit;   // same-cycle write to the looked-up bucket
    logic [DW-1:0]           byp_data;
    logic [DW-1:0]           hold;
    logic [DW-1:0]           rd_data;
    logic [DW-1:0]           res_data;

`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          init_pend <= 1'b1;
        else if (state == IDLE) init_pend <= 1'b0;
    end
`else
    assign init_pend = 1'b0;
`endif

    assign start_clr  = clear_ram_run_i || init_pend;
    assign clr_nxt    = clr_addr + 1'b1;
    assign lk_ready_o = (state == IDLE) && !init_pend && (!res_valid_o || res_ready_i);
    assign lk_fire    = lk_valid_i && lk_ready_o;

    // Port B: the clear sweep owns the write port; updates are dropped meanwhile.
    assign upd_we   = (state == IDLE) && upd_wr_en_i;
    assign upd_data = {upd_head_ptr_i, upd_head_ptr_val_i};
    assign we_b     = (state == CLEAR) || upd_we;
    assign addr_b   = (state == CLEAR) ? clr_addr : upd_bucket_i;
    assign data_b   = (state == CLEAR) ? '0 : upd_data;

    true_dual_port_ram_single_clock #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (BUCKET_WIDTH)
    ) u_ram (
        .clk_i  (clk_i),
        .en_a   (lk_fire),
        .we_a   (1'b0),
        .addr_a (lk_bucket_i),
        .data_a ('0),
        .q_a    (q_a),
        .we_b   (we_b),
        .addr_b (addr_b),
        .data_b (data_b)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            clr_addr         <= '0;
            clear_ram_done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clear_ram_done_o <= 1'b0;
                    if (start_clr) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_ram_run_i) begin
                        clr_addr         <= '0;
                        clear_ram_done_o <= 1'b0;
                    end else begin
                        clr_addr         <= clr_nxt;
                        // Registered so it is high while the last address is written.
                        clear_ram_done_o <= (clr_nxt == LAST_ADDR);
                        if (clr_addr == LAST_ADDR) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM reads old data on a same-edge write, so capture the write as a bypass.
    assign rd_data  = byp_hit ? byp_data : q_a;
    assign res_data = fresh ? rd_data : hold;
    assign {res_head_ptr_o, res_head_ptr_val_o} = res_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_valid_o  <= 1'b0;
            res_bucket_o <= '0;
            res_tag_o    <= '0;
            fresh        <= 1'b0;
            byp_hit      <= 1'b0;
            byp_data     <= '0;
            hold         <= '0;
        end else begin
            fresh <= lk_fire;
            if (fresh) hold <= rd_data;
            if (lk_fire) begin
                res_valid_o  <= 1'b1;
                res_bucket_o <= lk_bucket_i;
                res_tag_o    <= lk_tag_i;
                byp_hit      <= upd_we && (upd_bucket_i == lk_bucket_i);
                byp_data     <= upd_data;
            end else if (res_ready_i) begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_head_table.sv
module tb_head_table;
    import hash_table::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        lk_valid_i = 1'b0;
    logic        lk_ready_o;
    logic [7:0]  lk_bucket_i = '0;
    logic [31:0] lk_tag_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b1;
    logic [7:0]  res_bucket_o;
    logic [31:0] res_tag_o;
    logic [9:0]  res_head_ptr_o;
    logic        res_head_ptr_val_o;
    logic        upd_wr_en_i = 1'b0;
    logic [7:0]  upd_bucket_i = '0;
    logic [9:0]  upd_head_ptr_i = '0;
    logic        upd_head_ptr_val_i = 1'b0;
    logic        clear_ram_run_i = 1'b0;
    logic        clear_ram_done_o;

    int n_chk = 0;
    int n_err = 0;

    head_table #(.BUCKET_WIDTH(8), .HEAD_PTR_WIDTH(10), .TAG_WIDTH(32)) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .lk_valid_i         (lk_valid_i),
        .lk_ready_o         (lk_ready_o),
        .lk_bucket_i        (lk_bucket_i),
        .lk_tag_i           (lk_tag_i),
        .res_valid_o        (res_valid_o),
        .res_ready_i        (res_ready_i),
        .res_bucket_o       (res_bucket_o),
        .res_tag_o          (res_tag_o),
        .res_head_ptr_o     (res_head_ptr_o),
        .res_head_ptr_val_o (res_head_ptr_val_o),
        .upd_wr_en_i        (upd_wr_en_i),
        .upd_bucket_i       (upd_bucket_i),
        .upd_head_ptr_i     (upd_head_ptr_i),
        .upd_head_ptr_val_i (upd_head_ptr_val_i),
        .clear_ram_run_i    (clear_ram_run_i),
        .clear_ram_done_o   (clear_ram_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [7:0] b, input logic [9:0] p, input logic v);
        upd_wr_en_i = 1'b1; upd_bucket_i = b; upd_head_ptr_i = p; upd_head_ptr_val_i = v;
        step();
        upd_wr_en_i = 1'b0;
    endtask

    // Lookup with res_ready_i high; result checked at N+1, consumed in that cycle.
    task automatic look(input string tag, input logic [7:0] b, input logic [31:0] t,
                        input logic [9:0] ep, input logic ev);
        head_ram_data_t e;
        e.head_ptr = ep; e.head_ptr_val = ev;
        lk_valid_i = 1'b1; lk_bucket_i = b; lk_tag_i = t;
        chk({tag, "_rdy"}, lk_ready_o, 1);
        step();
        lk_valid_i = 1'b0;
        chk({tag, "_vld"}, res_valid_o, 1);
        chk({tag, "_data"}, {res_head_ptr_o, res_head_ptr_val_o}, e);
        chk({tag, "_tag"}, res_tag_o, t);
        chk({tag, "_bkt"}, res_bucket_o, b);
        step();
    endtask

    initial begin
        int pulses, at, acc, got;
        logic tog;

        // Reset state
        #12;
        chk("rst_vld", res_valid_o, 0);
        chk("rst_done", clear_ram_done_o, 0);
        chk("rst_rdy", lk_ready_o, 1);
        rst_n_i = 1'b1;
        step();

        // Full clear, then lookup bucket 0x05
        clear_ram_run_i = 1'b1;
        step();
        clear_ram_run_i = 1'b0;
        pulses = 0; at = 0;
        for (int k = 1; k <= 300; k++) begin
            if (clear_ram_done_o) begin pulses++; at = k; end
            if (k == 1) chk("clr_busy_rdy", lk_ready_o, 0);
            step();
        end
        chk("clr_pulses", pulses, 1);
        chk("clr_done_at", at, 256);
        look("clr_look05", 8'h05, 32'hC0DE_0005, 10'h000, 1'b0);

        // Update then lookup two cycles later
        upd(8'h12, 10'h3A7, 1'b1);
        step();
        look("upd_look12", 8'h12, 32'hDEAD_BEEF, 10'h3A7, 1'b1);
        chk("idle_vld", res_valid_o, 0);

        // Same-cycle update+lookup, then later update must not disturb held result
        upd_wr_en_i = 1'b1; upd_bucket_i = 8'h40; upd_head_ptr_i = 10'h001; upd_head_ptr_val_i = 1'b1;
        lk_valid_i = 1'b1; lk_bucket_i = 8'h40; lk_tag_i = 32'h0000_0040;
        step();
        lk_valid_i = 1'b0;
        chk("byp_vld", res_valid_o, 1);
        chk("byp_ptr", res_head_ptr_o, 10'h001);
        chk("byp_val", res_head_ptr_val_o, 1);
        res_ready_i = 1'b0;
        upd_head_ptr_i = 10'h002;
        step();
        upd_wr_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_vld", res_valid_o, 1);
            chk("hold_ptr", res_head_ptr_o, 10'h001);
            chk("hold_tag", res_tag_o, 32'h0000_0040);
            chk("hold_rdy", lk_ready_o, 0);
            step();
        end
        res_ready_i = 1'b1;
        step();
        look("post_hold40", 8'h40, 32'h1111_2222, 10'h002, 1'b1);

        // Back-to-back lookups 0x00..0x0F with toggling res_ready_i
        for (int i = 0; i < 16; i++) upd(i[7:0], 10'h100 + 10'(i), 1'b1);
        acc = 0; got = 0; tog = 1'b1;
        for (int c = 0; c < 200 && got < 16; c++) begin
            lk_valid_i = (acc < 16);
            lk_bucket_i = acc[7:0];
            lk_tag_i = 32'hA000_0000 + acc;
            res_ready_i = tog;
            tog = ~tog;
            #1;
            if (res_valid_o && !res_ready_i) chk("stall_rdy", lk_ready_o, 0);
            if (res_valid_o && res_ready_i) begin
                chk("strm_bkt", res_bucket_o, got[7:0]);
                chk("strm_ptr", res_head_ptr_o, 10'h100 + 10'(got));
                chk("strm_tag", res_tag_o, 32'hA000_0000 + got);
                got++;
            end
            if (lk_valid_i && lk_ready_o) acc++;
            step();
        end
        chk("strm_cnt", got, 16);
        lk_valid_i = 1'b0;
        res_ready_i = 1'b1;
        step();

        // Clear with same-cycle lookup, restart at 0x80, update during CLEAR dropped
        upd(8'h33, 10'h155, 1'b1);
        clear_ram_run_i = 1'b1;
        lk_valid_i = 1'b1; lk_bucket_i = 8'h33; lk_tag_i = 32'h5555_0033;
        step();
        clear_ram_run_i = 1'b0;
        lk_valid_i = 1'b0;
        pulses = 0; at = 0;
        for (int k = 1; k <= 420; k++) begin
            if (k == 1) begin
                chk("pre_clr_vld", res_valid_o, 1);
                chk("pre_clr_ptr", res_head_ptr_o, 10'h155);
                chk("pre_clr_val", res_head_ptr_val_o, 1);
            end
            if (clear_ram_done_o) begin pulses++; at = k; end
            clear_ram_run_i = (k == 129);
            upd_wr_en_i = (k == 230);
            upd_bucket_i = 8'h10; upd_head_ptr_i = 10'h2AA; upd_head_ptr_val_i = 1'b1;
            step();
        end
        clear_ram_run_i = 1'b0;
        upd_wr_en_i = 1'b0;
        chk("rst_clr_pulses", pulses, 1);
        chk("rst_clr_at", at, 385);
        look("cleared10", 8'h10, 32'h0000_0010, 10'h000, 1'b0);
        look("cleared33", 8'h33, 32'h0000_0033, 10'h000, 1'b0);

        // Reset mid-sweep: no done pulse, back to IDLE
        clear_ram_run_i = 1'b1;
        step();
        clear_ram_run_i = 1'b0;
        for (int k = 0; k < 20; k++) step();
        rst_n_i = 1'b0;
        #2;
        chk("midrst_done", clear_ram_done_o, 0);
        chk("midrst_rdy", lk_ready_o, 1);
        rst_n_i = 1'b1;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            if (clear_ram_done_o) pulses++;
            step();
        end
        chk("midrst_pulses", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
